// File: rtl/apb_slave_regfile_param_if.sv
// APB3 bus bundle for apb_slave_regfile_param.
// Pstrb exists only when APB_PSTRB_EN is defined.
interface apb_slave_regfile_param_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   Paddr;
    logic                    Psel;
    logic                    Penable;
    logic                    Pwrite;
    logic [DATA_WIDTH-1:0]   Pwdata;
`ifdef APB_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] Pstrb;
`endif
    logic                    Pready;
    logic [DATA_WIDTH-1:0]   Prdata;
    logic                    Pslverr;

`ifdef APB_PSTRB_EN
    modport slave  (input  Paddr, Psel, Penable, Pwrite, Pwdata, Pstrb,
                    output Pready, Prdata, Pslverr);
    modport master (output Paddr, Psel, Penable, Pwrite, Pwdata, Pstrb,
                    input  Pready, Prdata, Pslverr);
`else
    modport slave  (input  Paddr, Psel, Penable, Pwrite, Pwdata,
                    output Pready, Prdata, Pslverr);
    modport master (output Paddr, Psel, Penable, Pwrite, Pwdata,
                    input  Pready, Prdata, Pslverr);
`endif
endinterface

// File: rtl/apb_slave_regfile_param.sv
// Parametrised APB3 slave register file with wait states and PSLVERR.
// Optional byte strobes: define APB_PSTRB_EN.
module apb_slave_regfile_param #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic PCLK,
    input logic Preset,
    apb_slave_regfile_param_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
`ifdef APB_PSTRB_EN
    localparam int NBYTES = DATA_WIDTH/8;
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  ready;
    logic                  in_range;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    assign in_range = ({1'b0, bus.Paddr} < DEPTH_L);
    assign idx      = IDX_W'(bus.Paddr);
    assign wr_en    = ready & bus.Psel & bus.Penable & bus.Pwrite & in_range;

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Penable is not looked at in IDLE so masters holding it high still get a setup phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.Psel) begin
                    state_n = ACCESS;
                    cnt_n   = WS;
                end
            end
            ACCESS: begin
                if (!bus.Psel) begin
                    state_n = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (bus.Penable) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pready depends only on registered state, never on bus inputs.
    always_comb begin
        ready       = (state == ACCESS) && (cnt == 4'd0);
        bus.Pready  = ready;
        bus.Pslverr = ready & ~in_range;
        bus.Prdata  = '0;
        if (ready && !bus.Pwrite && in_range)
            bus.Prdata = regs[idx];
    end

    always_ff @(posedge PCLK) begin
        if (Preset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= RESET_VALUE;
        end else if (wr_en) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < NBYTES; b++)
                if (bus.Pstrb[b])
                    regs[idx][8*b +: 8] <= bus.Pwdata[8*b +: 8];
`else
            regs[idx] <= bus.Pwdata;
`endif
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile_param.sv
// Scoreboard bench for apb_slave_regfile_param (DEPTH=12, WAIT_STATES=2).
// Build with APB_PSTRB_EN defined to exercise byte strobes.
module tb_apb_slave_regfile_param;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW/8;
    localparam int DEPTH = 12;
    localparam int WS    = 2;
    localparam logic [DW-1:0] RV = '0;

    logic PCLK = 1'b0;
    logic Preset = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_slave_regfile_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_slave_regfile_param #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .WAIT_STATES(WS), .RESET_VALUE(RV)
    ) dut (
        .PCLK(PCLK),
        .Preset(Preset),
        .bus(bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [DW-1:0] mdl [2**AW];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2**AW; i++) mdl[i] = RV;
    endfunction

    // Expected response from the register-file rules; writes update the model in bus order.
    function automatic void push_exp(input logic wr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic [NB-1:0] s);
        exp_t e;
        bit   inr;
        inr     = (int'(a) < DEPTH);
        e.wr    = wr;
        e.addr  = a;
        e.err   = !inr;
        e.rdata = (!wr && inr) ? mdl[a] : '0;
        if (wr && inr)
            for (int b = 0; b < NB; b++)
                if (s[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        sbq.push_back(e);
    endfunction

    always @(negedge PCLK) begin
        if (Preset) begin
            cyc = 0;
        end else if (bus.Pready) begin
            check("ready_in_access", DW'(bus.Psel && bus.Penable), 1);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got addr %0d expected no transfer", bus.Paddr);
            end else begin
                mon_e = sbq.pop_front();
                check($sformatf("prdata[%0d]", mon_e.addr), bus.Prdata, mon_e.rdata);
                check($sformatf("pslverr[%0d]", mon_e.addr), DW'(bus.Pslverr), DW'(mon_e.err));
                check("latency", DW'(cyc), DW'(WS + 1));
            end
            cyc = 0;
        end else begin
            check("idle_pslverr", DW'(bus.Pslverr), 0);
            check("idle_prdata", bus.Prdata, 0);
            cyc = bus.Psel ? cyc + 1 : 0;
        end
    end

    // Entered and left 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s, input bit legacy, input bit keep,
                        input int abort_after);
        logic [NB-1:0] se;
        int n;
`ifdef APB_PSTRB_EN
        se = s;
        bus.Pstrb = s;
`else
        se = '1;
`endif
        bus.Psel = 1'b1;
        bus.Penable = legacy;
        bus.Pwrite = wr;
        bus.Paddr = a;
        bus.Pwdata = d;
        if (abort_after < 0) push_exp(wr, a, d, se);
        @(posedge PCLK); #1;
        bus.Penable = 1'b1;
        if (abort_after >= 0) begin
            repeat (abort_after) begin @(posedge PCLK); #1; end
            bus.Psel = 1'b0;
            bus.Penable = 1'b0;
            @(posedge PCLK); #1;
            return;
        end
        n = 0;
        while (!bus.Pready && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!bus.Pready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no Pready in %0d cycles expected %0d", n, WS);
            void'(sbq.pop_back());
            bus.Psel = 1'b0;
            bus.Penable = 1'b0;
            @(posedge PCLK); #1;
            return;
        end
        @(posedge PCLK); #1;
        if (!keep) begin
            bus.Psel = 1'b0;
            bus.Penable = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bus.Psel = 1'b0;
        bus.Penable = 1'b0;
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    initial begin
        bus.Psel = 1'b0;
        bus.Penable = 1'b0;
        bus.Pwrite = 1'b0;
        bus.Paddr = '0;
        bus.Pwdata = '0;
`ifdef APB_PSTRB_EN
        bus.Pstrb = '0;
`endif
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_pready", DW'(bus.Pready), 0);
        check("reset_pslverr", DW'(bus.Pslverr), 0);
        check("reset_prdata", bus.Prdata, 0);
        Preset = 1'b0;
        idle(1);

        xfer(1, 4'd3, 32'hA5A50001, '1, 0, 0, -1);
        xfer(0, 4'd3, '0, '1, 0, 0, -1);
        xfer(1, 4'd4, 32'h12345678, '1, 0, 0, -1);

        // Reset for two edges in the middle of a write to address 4.
        bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
        bus.Paddr = 4'd4; bus.Pwdata = 32'hFFFF0000;
        @(posedge PCLK); #1;
        bus.Penable = 1'b1;
        Preset = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        check("midreset_pready", DW'(bus.Pready), 0);
        check("midreset_pslverr", DW'(bus.Pslverr), 0);
        check("midreset_prdata", bus.Prdata, 0);
        Preset = 1'b0;
        model_reset();
        idle(1);
        for (int a = 0; a < 16; a++) xfer(0, AW'(a), '0, '1, 0, 0, -1);

        // Legacy master: Psel and Penable held high across back-to-back transfers.
        for (int a = 0; a < 16; a++) xfer(1, AW'(a), DW'(a + 1), '1, 1, 1, -1);
        for (int a = 0; a < 16; a++) xfer(0, AW'(a), '0, '1, 1, 1, -1);
        idle(1);

        xfer(1, 4'd13, 32'hDEADBEEF, '1, 0, 0, -1);
        xfer(0, 4'd13, '0, '1, 0, 0, -1);
        xfer(0, 4'd11, '0, '1, 0, 0, -1);
        for (int a = 0; a < DEPTH; a++) xfer(0, AW'(a), '0, '1, 0, 0, -1);

        xfer(1, 4'd5, 32'h000055AA, '1, 0, 0, -1);
        xfer(1, 4'd5, 32'h00000BAD, '1, 0, 0, 1);
        xfer(0, 4'd5, '0, '1, 0, 0, -1);
        xfer(1, 4'd6, 32'h600D600D, '1, 0, 0, -1);
        xfer(0, 4'd6, '0, '1, 0, 0, -1);

`ifdef APB_PSTRB_EN
        xfer(1, 4'd2, 32'h11223344, 4'b1111, 0, 0, -1);
        xfer(1, 4'd2, 32'hAABBCCDD, 4'b0101, 0, 0, -1);
        xfer(0, 4'd2, '0, 4'b0000, 0, 0, -1);
        xfer(1, 4'd2, 32'h99999999, 4'b0000, 0, 0, -1);
        xfer(0, 4'd2, '0, 4'b1010, 0, 0, -1);
`endif

        for (int i = 0; i < 200; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [NB-1:0] s;
            bit            legacy, keep;
            int            ab;
            wr     = 1'($urandom_range(0, 1));
            a      = AW'($urandom_range(0, 15));
            d      = $urandom;
            s      = NB'($urandom);
            legacy = 1'($urandom_range(0, 1));
            keep   = legacy && ($urandom_range(0, 1) == 1);
            ab     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            xfer(wr, a, d, s, legacy, keep, ab);
            if (!keep || ab >= 0) idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_empty", DW'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
